if_stage: RTL

- Instruction-fetch stage of the 5-stage pipeline.
- Maintains the fetch PC and fetches one 32-bit instruction per bus transaction from the shared bus as a bus master.
- Drives the IF/ID pipeline register (if_pc, if_insn, if_en) consumed by the decode stage.
- Honours global stall/flush from the pipeline controller, and redirects on br_taken/br_addr from decode.

---
 rtl/if_stage_pkg.sv | 15 +
 rtl/if_bus_if.sv | 67 ++++++
 rtl/if_stage.sv | 52 +++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared fetch-stage constants, bus state encodings and word types
package if_stage_pkg;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  typedef logic [ADDR_W-1:0] word_addr_t;
  typedef logic [DATA_W-1:0] word_t;
  localparam logic [1:0] BUS_IDLE   = 2'd0;
  localparam logic [1:0] BUS_REQ    = 2'd1;
  localparam logic [1:0] BUS_ACCESS = 2'd2;
  localparam logic [1:0] BUS_STALL  = 2'd3;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam word_t NOP_INSN_DEFAULT = 32'h0;
endpackage

// File: rtl/if_bus_if.sv
// if_bus_if: fetch bus master FSM; ports: clk/reset, stall/flush, fetch addr in, busy/done/data out, bus_* master signals
module if_bus_if
  import if_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data,
  output logic              bus_req_,
  input  logic              bus_grant_,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);
  logic [1:0]        state;
  logic              flush_seen;
  logic [DATA_W-1:0] rd_buf;
  assign bus_rw      = READ;
  assign bus_wr_data = '0;
  assign busy = (state == BUS_REQ) || (state == BUS_ACCESS && bus_rdy_ == DISABLE_);
  // a transfer that saw a flush still runs to completion on the bus but never delivers
  assign done = (state == BUS_ACCESS && bus_rdy_ == ENABLE_ && !flush_seen) || state == BUS_STALL;
  assign data = state == BUS_STALL ? rd_buf : bus_rd_data;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= BUS_IDLE;
      flush_seen <= 1'b0;
      rd_buf     <= '0;
      bus_req_   <= DISABLE_;
      bus_as_    <= DISABLE_;
      bus_addr   <= '0;
    end else begin
      case (state)
        BUS_IDLE: if (!flush) begin
          bus_req_ <= ENABLE_;
          state    <= BUS_REQ;
        end
        BUS_REQ: if (flush) begin
          bus_req_ <= DISABLE_;
          state    <= BUS_IDLE;
        end else if (bus_grant_ == ENABLE_) begin
          bus_as_  <= ENABLE_;
          bus_addr <= addr;
          state    <= BUS_ACCESS;
        end
        BUS_ACCESS: begin
          bus_as_ <= DISABLE_;
          if (flush) flush_seen <= 1'b1;
          if (bus_rdy_ == ENABLE_) begin
            bus_req_   <= DISABLE_;
            rd_buf     <= bus_rd_data;
            flush_seen <= 1'b0;
            state      <= (flush || flush_seen) ? BUS_IDLE : stall ? BUS_STALL : BUS_IDLE;
          end
        end
        BUS_STALL: if (!stall || flush) state <= BUS_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage; ports: clk/reset, stall/flush/new_pc, br_taken/br_addr, busy, bus_* master, IF/ID register (if_pc, if_insn, if_en)
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 30'h0,
  parameter logic [DATA_W-1:0] NOP_INSN     = NOP_INSN_DEFAULT
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              busy,
  output logic              bus_req_,
  input  logic              bus_grant_,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_en
);
  logic              done;
  logic [DATA_W-1:0] data;
  if_bus_if u_bus (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .addr(if_pc),
    .busy(busy), .done(done), .data(data),
    .bus_req_(bus_req_), .bus_grant_(bus_grant_), .bus_as_(bus_as_), .bus_rw(bus_rw),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
  );
  // if_pc doubles as the fetch address, so it advances past the fetched word on delivery
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_pc   <= RESET_VECTOR;
      if_insn <= NOP_INSN;
      if_en   <= 1'b0;
    end else if (flush) begin
      if_pc   <= new_pc;
      if_insn <= NOP_INSN;
      if_en   <= 1'b0;
    end else if (!(stall || busy)) begin
      if_pc   <= done ? (br_taken ? br_addr : if_pc + 30'd1) : if_pc;
      if_insn <= done ? data : NOP_INSN;
      if_en   <= done;
    end
  end
endmodule
